// File: rtl/pipelined_solver.sv
// pipelined_solver: STAGES-deep valid/ready pipeline evaluating a programmable truth table on CHANNELS lanes.
// Define SOLVER_STATS_EN to add output handshake counters stat_total and stat_ones.
module pipelined_solver #(
    parameter int WIDTH = 5,
    parameter int CHANNELS = 1,
    parameter int STAGES = 3,
    parameter logic [2**WIDTH-1:0] TT_RESET = '0
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      load,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      tt_we,
    input  logic [2**WIDTH-1:0]       tt_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       out_f,
    output logic                      busy
`ifdef SOLVER_STATS_EN
    ,
    output logic [15:0]               stat_ones,
    output logic [15:0]               stat_total
`endif
);
    logic [2**WIDTH-1:0] tt;
    logic [CHANNELS*WIDTH-1:0] x0;
    logic [STAGES-1:0] v, en;
    logic [CHANNELS-1:0] r [1:STAGES-1];
    logic [CHANNELS-1:0] f;
    logic full;

    // A stage can take new data unless it and every stage after it are full while the output stalls.
    always_comb begin
        full = 1'b1;
        en = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            full = full && v[i];
            en[i] = out_ready || !full;
        end
    end

    always_comb begin
        f = '0;
        for (int k = 0; k < CHANNELS; k++) f[k] = tt[x0[k*WIDTH +: WIDTH]];
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            tt <= TT_RESET;
            v <= '0;
            x0 <= '0;
            for (int i = 1; i < STAGES; i++) r[i] <= '0;
        end else begin
            if (tt_we) tt <= tt_data;
            if (en[0]) v[0] <= load;
            if (en[0] && load) x0 <= in_data;
            if (en[1]) begin
                v[1] <= v[0];
                r[1] <= f;
            end
            for (int i = 2; i < STAGES; i++) begin
                if (en[i]) begin
                    v[i] <= v[i-1];
                    r[i] <= r[i-1];
                end
            end
        end
    end

    assign in_ready = en[0];
    assign out_valid = v[STAGES-1];
    assign out_f = v[STAGES-1] ? r[STAGES-1] : '0;
    assign busy = |v;

`ifdef SOLVER_STATS_EN
    logic [15:0] ones;

    always_comb begin
        ones = '0;
        for (int k = 0; k < CHANNELS; k++) ones = ones + 16'(out_f[k]);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            stat_ones <= '0;
            stat_total <= '0;
        end else if (out_valid && out_ready) begin
            stat_ones <= stat_ones + ones;
            stat_total <= stat_total + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipelined_solver.sv
// tb_pipelined_solver: directed checks of latency, stalls, table updates and clear on the solver pipeline.
module tb_pipelined_solver;
    logic clock = 1'b0;
    logic clear = 1'b1;
    logic load = 1'b0, tt_we = 1'b0, out_ready = 1'b1;
    logic [4:0] in_data = '0;
    logic [31:0] tt_data = '0;
    logic in_ready, out_valid, busy;
    logic [0:0] out_f;
    logic load4 = 1'b0, tt_we4 = 1'b0;
    logic [19:0] in_data4 = '0;
    logic [31:0] tt_data4 = '0;
    logic in_ready4, out_valid4, busy4;
    logic [3:0] out_f4;
    int n_tests = 0, n_fail = 0;
`ifdef SOLVER_STATS_EN
    logic [15:0] stat_ones, stat_total, stat_ones4, stat_total4;
`endif

    always #5 clock = ~clock;

    pipelined_solver u_dut (
        .clock(clock), .clear(clear), .load(load), .in_ready(in_ready), .in_data(in_data),
        .tt_we(tt_we), .tt_data(tt_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .busy(busy)
`ifdef SOLVER_STATS_EN
        , .stat_ones(stat_ones), .stat_total(stat_total)
`endif
    );

    pipelined_solver #(.CHANNELS(4)) u_dut4 (
        .clock(clock), .clear(clear), .load(load4), .in_ready(in_ready4), .in_data(in_data4),
        .tt_we(tt_we4), .tt_data(tt_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_f(out_f4), .busy(busy4)
`ifdef SOLVER_STATS_EN
        , .stat_ones(stat_ones4), .stat_total(stat_total4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        step(2);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_f", 32'(out_f), 0);
        check("rst_ready4", 32'(in_ready4), 1);
        check("rst_valid4", 32'(out_valid4), 0);
        clear = 1'b0;
        // Program tables, then one operand: visible after the third edge counting the accepting one
        tt_we = 1'b1; tt_data = 32'h0000_0004;
        tt_we4 = 1'b1; tt_data4 = 32'h8000_0009;
        step;
        tt_we = 1'b0; tt_we4 = 1'b0;
        load = 1'b1; in_data = 5'b00010;
        load4 = 1'b1; in_data4 = {5'h1F, 5'h00, 5'h03, 5'h10};
        step;
        load = 1'b0; load4 = 1'b0;
        check("lat1_valid", 32'(out_valid), 0);
        step;
        check("lat2_valid", 32'(out_valid), 0);
        step;
        check("lat3_valid", 32'(out_valid), 1);
        check("f_00010", 32'(out_f), 1);
        check("lanes_valid", 32'(out_valid4), 1);
        check("lanes_f", 32'(out_f4), 32'hE);
        load = 1'b1; in_data = 5'b00001;
        step;
        load = 1'b0;
        check("drain_valid", 32'(out_valid), 0);
        check("drain_f", 32'(out_f), 0);
        step;
        check("f_00001_valid", 32'(out_valid), 0);
        step;
        check("f_00001_valid2", 32'(out_valid), 1);
        check("f_00001", 32'(out_f), 0);
        step;
        check("empty_valid", 32'(out_valid), 0);
        // Stalled output: pipe fills to three items, then in_ready drops
        out_ready = 1'b0; load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = (i == 1) ? 5'd1 : 5'd2;
            check("fill_ready", 32'(in_ready), 1);
            step;
        end
        check("full_ready", 32'(in_ready), 0);
        check("full_busy", 32'(busy), 1);
        check("full_f", 32'(out_f), 1);
        in_data = 5'd3;
        step;
        check("stall_ready", 32'(in_ready), 0);
        check("stall_valid", 32'(out_valid), 1);
        check("stall_f", 32'(out_f), 1);
        out_ready = 1'b1;
        #1;
        check("release_ready", 32'(in_ready), 1);
        step;
        load = 1'b0;
        check("order_b_valid", 32'(out_valid), 1);
        check("order_b", 32'(out_f), 0);
        step;
        check("order_c", 32'(out_f), 1);
        step;
        check("order_d_valid", 32'(out_valid), 1);
        check("order_d", 32'(out_f), 0);
        step;
        check("order_end", 32'(out_valid), 0);
        // Table rewrite with two looked-up items held in stages 1 and 2
        out_ready = 1'b0; load = 1'b1; in_data = 5'd2;
        step(2);
        load = 1'b0;
        step;
        check("tt_busy", 32'(busy), 1);
        tt_we = 1'b1; tt_data = 32'hFFFF_FFFB; load = 1'b1; in_data = 5'd2;
        step;
        tt_we = 1'b0; load = 1'b0; out_ready = 1'b1;
        check("old_p", 32'(out_f), 1);
        step;
        check("old_q", 32'(out_f), 1);
        step;
        check("new_r_valid", 32'(out_valid), 1);
        check("new_r", 32'(out_f), 0);
        step;
        check("tt_end", 32'(out_valid), 0);
        // Asynchronous clear with two items in flight
        load = 1'b1; in_data = 5'd1;
        step(2);
        load = 1'b0;
        check("pre_clear_busy", 32'(busy), 1);
        #2 clear = 1'b1;
        #1;
        check("clr_valid", 32'(out_valid), 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_ready", 32'(in_ready), 1);
        check("clr_f", 32'(out_f), 0);
        step;
        clear = 1'b0;
        load = 1'b1; in_data = 5'd0;
        step;
        load = 1'b0;
        step(2);
        check("clr_tt_valid", 32'(out_valid), 1);
        check("clr_tt_f", 32'(out_f), 0);
        step;
`ifdef SOLVER_STATS_EN
        clear = 1'b1;
        step;
        clear = 1'b0;
        tt_we = 1'b1; tt_data = 32'h0000_0004;
        step;
        tt_we = 1'b0;
        check("stat_total0", 32'(stat_total), 0);
        load = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = (i < 6) ? 5'd2 : 5'd1;
            step;
        end
        load = 1'b0;
        step(4);
        check("stat_total", 32'(stat_total), 10);
        check("stat_ones", 32'(stat_ones), 6);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
